uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
//  - Grants one requester at a time and latches its byte.
//  - Drives the uart_tx valid/ready handshake and holds off further grants until the frame completes.
//  - Sits between producer blocks and the uart_if data/valid/ready signals of uart_tx.

---
 rtl/uart_arb_pkg.sv | 43 ++++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// index-width helper and the round-robin pick function.
package uart_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] index;
  } rr_pick_t;

  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Walks offsets high to low so the lowest offset from ptr (highest priority) wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int                   n);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int off = MAX_REQ - 1; off >= 0; off--) begin
      if (off < n) begin
        idx = int'(ptr) + off;
        if (idx >= n) idx = idx - n;
        if (req[idx]) begin
          res.found = 1'b1;
          res.index = MAX_IDX_W'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin pick over the pending requests plus the rotating priority pointer,
// which advances past the winner whenever a grant is taken.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0]     ptr_d, ptr_q;
  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;
  rr_pick_t             pick;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
    ptr_ext              = MAX_IDX_W'(ptr_q);
    pick                 = rr_pick(req_ext, ptr_ext, NUM_REQ);
    found_o              = pick.found;
    idx_o                = IDX_W'(pick.index);
    ptr_d                = ptr_q;
    if (grant_i) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers (round-robin).
// Optional handshake timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [req_idx_w(NUM_REQ)-1:0] grant_id,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  arb_state_e            state_d, state_q;
  logic [DATA_WIDTH-1:0] tx_data_d, tx_data_q;
  logic [IDX_W-1:0]      grant_id_d, grant_id_q;
  logic [NUM_REQ-1:0]    ack_d, ack_q;
  logic                  tx_valid_d, tx_valid_q;
  logic                  grant;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic                  timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_valid),
    .grant_i (grant),
    .found_o (found),
    .idx_o   (win_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;

  always_comb begin
    cnt_d       = (state_q == LAUNCH) ? cnt_q + 1'b1 : '0;
    timeout_hit = (state_q == LAUNCH) && tx_ready && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    err_d       = err_q | timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    tx_valid_d = tx_valid_q;
    grant      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && tx_ready) begin
          grant          = 1'b1;
          tx_data_d      = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d     = win_idx;
          ack_d[win_idx] = 1'b1;
          tx_valid_d     = 1'b1;
          state_d        = LAUNCH;
        end
      end
      LAUNCH: begin
        // Serializer dropping ready means it took the byte; a timeout abandons it.
        if (!tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = DRAIN;
        end else if (timeout_hit) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign req_ack  = ack_q;
  assign grant_id = grant_id_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants checked by a monitor,
// plus per-scenario inline checks. Timeout scenario runs only with UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int ACK_TO  = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic [1:0]            grant_id;
  logic [DW-1:0]         tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b1;
  logic                  busy;
  logic                  timeout_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [NUM_REQ-1:0] prev_ack = '0;
  int   ready_mode = 0;
  int   rdy_busy   = 0;

  uart_tx_arbiter #(
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NUM_REQ),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant_id    (grant_id),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Serializer model: 0 = normal (ready drops 1 cycle after valid, back 20 cycles later),
  // 1 = forced low, 2 = stuck high.
  always @(negedge clk) begin
    if (rst) begin
      tx_ready = 1'b1;
      rdy_busy = 0;
    end else if (ready_mode == 1) begin
      tx_ready = 1'b0;
      rdy_busy = 0;
    end else if (ready_mode == 2) begin
      tx_ready = 1'b1;
      rdy_busy = 0;
    end else if (rdy_busy > 0) begin
      rdy_busy = rdy_busy - 1;
      if (rdy_busy == 0) tx_ready = 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_ready = 1'b0;
      rdy_busy = 20;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Grant monitor: every ack must match the next scoreboard entry and last exactly one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = '0;
    end else begin
      if (req_ack !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant: got ack=%b grant_id=%0d expected no grant", req_ack, grant_id);
        end else begin
          mon_e = sb.pop_front();
          if (grant_id !== mon_e.id || tx_data !== mon_e.data ||
              req_ack !== (4'b0001 << mon_e.id) || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL grant: got id=%0d data=%h ack=%b valid=%b expected id=%0d data=%h valid=1",
                     grant_id, tx_data, req_ack, tx_valid, mon_e.id, mon_e.data);
          end
        end
        checks++;
        if (prev_ack !== '0) begin
          failures++;
          $display("FAIL ack_pulse: got ack high on consecutive cycles (%b then %b) expected one-cycle pulse",
                   prev_ack, req_ack);
        end
      end
      prev_ack = req_ack;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    ready_mode = 0;
    step();
    step();
    sb.delete();
    rst = 1'b0;
    step();
  endtask

  // Waits until every pushed grant is seen; optionally withdraws each acked request.
  task automatic wait_sb(input int budget, input bit drop, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (drop && req_ack !== '0) req_valid = req_valid & ~req_ack;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0 && tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    ready_mode = 0;
    step();
    step();
    checks++;
    if ({req_ack, grant_id, tx_data, tx_valid, busy, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got ack=%b id=%0d data=%h valid=%b busy=%b err=%b expected all 0",
               req_ack, grant_id, tx_data, tx_valid, busy, timeout_err);
    end
    rst = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({req_ack, grant_id, tx_data, tx_valid, busy, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_release: got ack=%b id=%0d data=%h valid=%b busy=%b err=%b expected all 0",
               req_ack, grant_id, tx_data, tx_valid, busy, timeout_err);
    end
  endtask

  task automatic test_single();
    int bad = 0;
    bit ok;
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    sb.push_back('{2'd0, 8'hA5});
    step();
    checks++;
    if (tx_valid !== 1'b1 || req_ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_latency: got valid=%b ack=%b id=%0d data=%h expected 1 0001 0 a5",
               tx_valid, req_ack, grant_id, tx_data);
    end
    req_valid     = '0;
    req_data[7:0] = 8'hFF;
    step();
    checks++;
    if (req_ack !== 4'b0000 || busy !== 1'b1 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_launch: got ack=%b busy=%b data=%h expected 0000 1 a5", req_ack, busy, tx_data);
    end
    for (int i = 0; i < 40 && tx_ready === 1'b0; i++) begin
      if (busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_busy: got %0d idle cycles while tx_ready low expected 0", bad);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got busy=%b valid=%b expected 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    sb.push_back('{2'd0, 8'h10});
    sb.push_back('{2'd1, 8'h11});
    sb.push_back('{2'd2, 8'h12});
    sb.push_back('{2'd3, 8'h13});
    sb.push_back('{2'd0, 8'h10});
    wait_sb(300, 1'b0, ok);
    req_valid = '0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_sequence: got %0d grants still pending expected 0", sb.size());
    end
    wait_idle(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_pointer();
    bit ok;
    do_reset();
    req_data[23:16] = 8'h22;
    req_valid       = 4'b0100;
    sb.push_back('{2'd2, 8'h22});
    wait_sb(50, 1'b1, ok);
    wait_idle(60, ok);
    req_data[15:8]  = 8'h31;
    req_data[31:24] = 8'h33;
    req_valid       = 4'b1010;
    sb.push_back('{2'd3, 8'h33});
    sb.push_back('{2'd1, 8'h31});
    wait_sb(150, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ptr_order: got %0d grants still pending expected 0", sb.size());
    end
    wait_idle(60, ok);
    step();
    checks++;
    if (grant_id !== 2'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ptr_hold: got id=%0d busy=%b expected 1 0", grant_id, busy);
    end
  endtask

  task automatic test_ready_low();
    int bad = 0;
    bit ok;
    do_reset();
    ready_mode = 1;
    step();
    req_data[23:16] = 8'h44;
    req_valid       = 4'b0100;
    sb.push_back('{2'd2, 8'h44});
    for (int i = 0; i < 4; i++) begin
      step();
      if (req_ack !== '0 || tx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ready_low_hold: got %0d cycles with ack/valid expected 0", bad);
    end
    ready_mode = 0;
    step();
    checks++;
    if (tx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_release_early: got valid=%b ready=%b expected 0 1", tx_valid, tx_ready);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || req_ack !== 4'b0100) begin
      failures++;
      $display("FAIL ready_release_grant: got valid=%b ack=%b expected 1 0100", tx_valid, req_ack);
    end
    req_valid = '0;
    wait_idle(60, ok);
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    do_reset();
    req_data[15:8] = 8'h55;
    req_valid      = 4'b0010;
    sb.push_back('{2'd1, 8'h55});
    wait_sb(50, 1'b1, ok);
    for (int i = 0; i < 5 && !(busy === 1'b1 && tx_valid === 1'b0); i++) step();
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_reach: got busy=%b valid=%b expected 1 0", busy, tx_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || req_ack !== '0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL drain_reset: got valid=%b ack=%b busy=%b id=%0d expected 0 0000 0 0",
               tx_valid, req_ack, busy, grant_id);
    end
    step();
    step();
    rst             = 1'b0;
    req_data[7:0]   = 8'h60;
    req_data[31:24] = 8'h63;
    req_valid       = 4'b1001;
    sb.push_back('{2'd0, 8'h60});
    sb.push_back('{2'd3, 8'h63});
    wait_sb(150, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_regrant: got %0d grants still pending expected 0", sb.size());
    end
    wait_idle(60, ok);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int vcnt = 0;
    bit ok;
    do_reset();
    ready_mode = 2;
    step();
    req_data[7:0] = 8'h77;
    req_valid     = 4'b0001;
    sb.push_back('{2'd0, 8'h77});
    step();
    req_valid = '0;
    checks++;
    if (tx_valid !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_launch: got valid=%b err=%b expected 1 0", tx_valid, timeout_err);
    end
    while (tx_valid === 1'b1 && vcnt < 40) begin
      vcnt++;
      step();
    end
    checks++;
    if (vcnt != ACK_TO || timeout_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_expire: got valid_cycles=%0d err=%b busy=%b expected %0d 1 0",
               vcnt, timeout_err, busy, ACK_TO);
    end
    ready_mode = 0;
    step();
    req_data[23:16] = 8'h88;
    req_valid       = 4'b0100;
    sb.push_back('{2'd2, 8'h88});
    wait_sb(50, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL to_regrant: got %0d grants still pending expected 0", sb.size());
    end
    wait_idle(60, ok);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: got err=%b expected 1", timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_ready_low();
    test_reset_in_drain();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d unmatched expected grants expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
